// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO slave with per-bit direction, 2-flop input sync and per-bit edge interrupts.
// Optional pad-bus parity generation/checking is built when AHB_GPIO_PARITY_EN is defined.
module ahb_gpio_irq #(
  parameter int unsigned WIDTH     = 16,
  parameter logic [31:0] ADDR_BASE = 32'h5300_0000
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic             HREADY,
  input  logic [31:0]      HWDATA,
  output logic             HREADYOUT,
  output logic             HRESP,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH-1:0] GPIOIN,
  output logic [WIDTH-1:0] GPIOOUT,
  output logic [WIDTH-1:0] GPIOOEN,
  output logic             GPIOIRQ
`ifdef AHB_GPIO_PARITY_EN
  ,
  input  logic             GPIOINPAR,
  output logic             GPIOOUTPAR,
  output logic             PARITYERR
`endif
);

  typedef enum logic [5:0] {
    OFF_DATA     = 6'h00,
    OFF_DIR      = 6'h01,
    OFF_IRQ_EN   = 6'h02,
    OFF_IRQ_EDGE = 6'h03,
    OFF_STATUS   = 6'h04,
    OFF_PARCFG   = 6'h05
  } reg_off_e;

  logic             ph_valid;
  logic             ph_write;
  logic [5:0]       ph_off;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] irq_edge_q;
  logic [WIDTH-1:0] status_q;
  logic             irq_q;

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] in_sync_q;
  logic [WIDTH-1:0] in_d_q;

  logic             accept;
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rd_val;
  logic             unused_bits;

`ifdef AHB_GPIO_PARITY_EN
  logic odd_q;
  logic par_sync1_q;
  logic par_sync_q;
  logic parerr_q;
`endif

  assign accept = HSEL & HTRANS[1] & HREADY & (HADDR[31:8] == ADDR_BASE[31:8]);
  assign wr_en  = ph_valid & ph_write;
  assign wdata  = HWDATA[WIDTH-1:0];

  assign rise = in_sync_q & ~in_d_q;
  assign fall = ~in_sync_q & in_d_q;
  // Edge select is applied to the already-delayed samples, so retargeting IRQ_EDGE cannot fabricate an event.
  assign ev   = ((irq_edge_q & rise) | (~irq_edge_q & fall)) & ~dir_q;
  assign clr  = (wr_en && ph_off == OFF_STATUS) ? wdata : '0;

  assign unused_bits = ^{HADDR[1:0], HWDATA};

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      ph_valid   <= 1'b0;
      ph_write   <= 1'b0;
      ph_off     <= '0;
      out_q      <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      irq_edge_q <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
      sync1_q    <= '0;
      in_sync_q  <= '0;
      in_d_q     <= '0;
    end else begin
      ph_valid  <= accept;
      ph_write  <= HWRITE;
      ph_off    <= HADDR[7:2];
      sync1_q   <= GPIOIN;
      in_sync_q <= sync1_q;
      in_d_q    <= in_sync_q;
      // New events are OR-ed after the W1C mask so a same-cycle set wins.
      status_q  <= (status_q & ~clr) | ev;
      irq_q     <= |(status_q & irq_en_q);
      if (wr_en) begin
        case (ph_off)
          OFF_DATA:     out_q      <= (out_q & ~dir_q) | (wdata & dir_q);
          OFF_DIR:      dir_q      <= wdata;
          OFF_IRQ_EN:   irq_en_q   <= wdata;
          OFF_IRQ_EDGE: irq_edge_q <= wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef AHB_GPIO_PARITY_EN
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      odd_q       <= 1'b0;
      par_sync1_q <= 1'b0;
      par_sync_q  <= 1'b0;
      parerr_q    <= 1'b0;
    end else begin
      par_sync1_q <= GPIOINPAR;
      par_sync_q  <= par_sync1_q;
      parerr_q    <= ((^in_sync_q) ^ par_sync_q) != odd_q;
      if (wr_en && ph_off == OFF_PARCFG) odd_q <= HWDATA[0];
    end
  end

  assign GPIOOUTPAR = (^out_q) ^ odd_q;
  assign PARITYERR  = parerr_q;
`endif

  always_comb begin
    rd_val = '0;
    case (ph_off)
      OFF_DATA:     rd_val = (dir_q & out_q) | (~dir_q & in_sync_q);
      OFF_DIR:      rd_val = dir_q;
      OFF_IRQ_EN:   rd_val = irq_en_q;
      OFF_IRQ_EDGE: rd_val = irq_edge_q;
      OFF_STATUS:   rd_val = status_q;
`ifdef AHB_GPIO_PARITY_EN
      OFF_PARCFG:   rd_val[0] = odd_q;
`endif
      default:      rd_val = '0;
    endcase
  end

  always_comb begin
    HRDATA = '0;
    if (ph_valid && !ph_write) HRDATA[WIDTH-1:0] = rd_val;
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign GPIOOUT   = out_q;
  assign GPIOOEN   = dir_q;
  assign GPIOIRQ   = irq_q;

endmodule

// File: tb/tb_ahb_gpio_irq.sv
// Directed self-checking bench for ahb_gpio_irq; parity checks run only when AHB_GPIO_PARITY_EN is defined.
module tb_ahb_gpio_irq;

  localparam logic [31:0] BASE = 32'h5300_0000;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [15:0] GPIOIN;
  logic [15:0] GPIOOUT;
  logic [15:0] GPIOOEN;
  logic        GPIOIRQ;
`ifdef AHB_GPIO_PARITY_EN
  logic        GPIOINPAR;
  logic        GPIOOUTPAR;
  logic        PARITYERR;
`endif

  int checks = 0;
  int errors = 0;

  ahb_gpio_irq #(.WIDTH(16), .ADDR_BASE(BASE)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .GPIOIN(GPIOIN), .GPIOOUT(GPIOOUT),
    .GPIOOEN(GPIOOEN), .GPIOIRQ(GPIOIRQ)
`ifdef AHB_GPIO_PARITY_EN
    , .GPIOINPAR(GPIOINPAR), .GPIOOUTPAR(GPIOOUTPAR), .PARITYERR(PARITYERR)
`endif
  );

  always #5 HCLK = ~HCLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  // Full write: address phase, then data phase; returns after the committing edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    tick(1);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00;
    data = HRDATA;
    tick(1);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    HRESETn = 1'b0;
    tick(3);
    checks++; if (GPIOOUT !== 16'h0) begin errors++; $display("FAIL rst_gpioout got %h exp 0000", GPIOOUT); end
    checks++; if (GPIOOEN !== 16'h0) begin errors++; $display("FAIL rst_gpiooen got %h exp 0000", GPIOOEN); end
    checks++; if (GPIOIRQ !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", GPIOIRQ); end
    checks++; if (HREADYOUT !== 1'b1) begin errors++; $display("FAIL rst_hreadyout got %b exp 1", HREADYOUT); end
    checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL rst_hresp got %b exp 0", HRESP); end
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_hrdata got %h exp 0", HRDATA); end
    HRESETn = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      rd(BASE + 32'(i * 4), d);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_read off %0h got %h exp 0", i * 4, d); end
    end
  endtask

  task automatic test_decode;
    logic [31:0] d;
    wr(32'h5400_0004, 32'h0000_FFFF);
    HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = BASE + 32'h4;
    tick(1);
    HSEL = 1'b0; HWRITE = 1'b0; HWDATA = 32'h0000_00FF;
    tick(1);
    rd(BASE + 32'h4, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL decode_dir got %h exp 0", d); end
  endtask

  task automatic test_output;
    logic [31:0] d;
    wr(BASE + 32'h04, 32'h0000_00FF);
    wr(BASE + 32'h00, 32'h0000_A5A5);
    checks++; if (GPIOOUT !== 16'h00A5) begin errors++; $display("FAIL out_gpioout got %h exp 00a5", GPIOOUT); end
    checks++; if (GPIOOEN !== 16'h00FF) begin errors++; $display("FAIL out_gpiooen got %h exp 00ff", GPIOOEN); end
    GPIOIN = 16'h3C00;
    tick(3);
    rd(BASE + 32'h00, d);
    checks++; if (d !== 32'h0000_3CA5) begin errors++; $display("FAIL out_read_data got %h exp 00003ca5", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = BASE;
    tick(1);
    HWRITE = 1'b0; HADDR = BASE; HWDATA = 32'h0000_005A;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
    tick(1);
    checks++; if (d !== 32'h0000_3C5A) begin errors++; $display("FAIL b2b_read got %h exp 00003c5a", d); end
  endtask

  task automatic test_rise;
    logic [31:0] d;
    wr(BASE + 32'h04, 32'h0);
    GPIOIN = 16'h0000;
    tick(4);
    wr(BASE + 32'h10, 32'h0000_FFFF);
    wr(BASE + 32'h0C, 32'h0000_0001);
    wr(BASE + 32'h08, 32'h0000_0001);
    rd(BASE + 32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rise_pre_status got %h exp 0", d); end
    GPIOIN = 16'h0001;
    rd(BASE + 32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rise_status_e1 got %h exp 0", d); end
    checks++; if (GPIOIRQ !== 1'b0) begin errors++; $display("FAIL rise_irq_e2 got %b exp 0", GPIOIRQ); end
    rd(BASE + 32'h10, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rise_status_e3 got %h exp 1", d); end
    checks++; if (GPIOIRQ !== 1'b1) begin errors++; $display("FAIL rise_irq_e4 got %b exp 1", GPIOIRQ); end
    wr(BASE + 32'h10, 32'h1);
    checks++; if (GPIOIRQ !== 1'b1) begin errors++; $display("FAIL rise_irq_hold got %b exp 1", GPIOIRQ); end
    tick(1);
    checks++; if (GPIOIRQ !== 1'b0) begin errors++; $display("FAIL rise_irq_clear got %b exp 0", GPIOIRQ); end
    rd(BASE + 32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rise_status_clear got %h exp 0", d); end
  endtask

  task automatic test_fall_mask;
    logic [31:0] d;
    wr(BASE + 32'h0C, 32'h0);
    wr(BASE + 32'h08, 32'h0);
    GPIOIN = 16'h0009;
    tick(4);
    rd(BASE + 32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL fall_rise_ignored got %h exp 0", d); end
    GPIOIN = 16'h0001;
    tick(4);
    rd(BASE + 32'h10, d);
    checks++; if (d !== 32'h8) begin errors++; $display("FAIL fall_status got %h exp 8", d); end
    checks++; if (GPIOIRQ !== 1'b0) begin errors++; $display("FAIL fall_irq_masked got %b exp 0", GPIOIRQ); end
    wr(BASE + 32'h08, 32'h8);
    tick(1);
    checks++; if (GPIOIRQ !== 1'b1) begin errors++; $display("FAIL fall_irq_unmasked got %b exp 1", GPIOIRQ); end
    wr(BASE + 32'h08, 32'h0);
    wr(BASE + 32'h10, 32'h8);
    rd(BASE + 32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL fall_status_clear got %h exp 0", d); end
  endtask

  task automatic test_no_false_events;
    logic [31:0] d;
    wr(BASE + 32'h0C, 32'h0000_FFFF);
    tick(2);
    rd(BASE + 32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL edge_change_event got %h exp 0", d); end
    wr(BASE + 32'h04, 32'h0000_0010);
    GPIOIN = 16'h0011;
    tick(4);
    rd(BASE + 32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL output_bit_event got %h exp 0", d); end
    wr(BASE + 32'h04, 32'h0);
    GPIOIN = 16'h0001;
    tick(4);
    wr(BASE + 32'h10, 32'h0000_FFFF);
    wr(BASE + 32'h0C, 32'h0);
  endtask

  task automatic test_set_beats_clear;
    logic [31:0] d;
    GPIOIN = 16'h0005;
    tick(4);
    GPIOIN = 16'h0001;
    tick(1);
    wr(BASE + 32'h10, 32'h4);
    rd(BASE + 32'h10, d);
    checks++; if (d !== 32'h4) begin errors++; $display("FAIL set_beats_clear got %h exp 4", d); end
    wr(BASE + 32'h10, 32'h4);
    rd(BASE + 32'h10, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_plain got %h exp 0", d); end
  endtask

  task automatic test_mid_reset;
    wr(BASE + 32'h04, 32'h0000_00FF);
    wr(BASE + 32'h00, 32'h0000_0011);
    checks++; if (GPIOOUT !== 16'h0011) begin errors++; $display("FAIL midrst_pre got %h exp 0011", GPIOOUT); end
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = BASE;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h0000_0022;
    HRESETn = 1'b0;
    tick(1);
    HRESETn = 1'b1;
    checks++; if (GPIOOUT !== 16'h0) begin errors++; $display("FAIL midrst_gpioout got %h exp 0000", GPIOOUT); end
    checks++; if (GPIOOEN !== 16'h0) begin errors++; $display("FAIL midrst_gpiooen got %h exp 0000", GPIOOEN); end
    tick(1);
    checks++; if (GPIOOUT !== 16'h0) begin errors++; $display("FAIL midrst_dropped got %h exp 0000", GPIOOUT); end
    checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL midrst_hrdata got %h exp 0", HRDATA); end
  endtask

`ifdef AHB_GPIO_PARITY_EN
  task automatic test_parity;
    logic [31:0] d;
    wr(BASE + 32'h14, 32'h1);
    rd(BASE + 32'h14, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL par_cfg_read got %h exp 1", d); end
    wr(BASE + 32'h04, 32'h0000_FFFF);
    wr(BASE + 32'h00, 32'h0000_0003);
    checks++; if (GPIOOUTPAR !== 1'b1) begin errors++; $display("FAIL par_out got %b exp 1", GPIOOUTPAR); end
    wr(BASE + 32'h14, 32'h0);
    wr(BASE + 32'h04, 32'h0);
    GPIOIN = 16'h0001; GPIOINPAR = 1'b1;
    tick(4);
    checks++; if (PARITYERR !== 1'b0) begin errors++; $display("FAIL par_err_ok got %b exp 0", PARITYERR); end
    GPIOINPAR = 1'b0;
    tick(4);
    checks++; if (PARITYERR !== 1'b1) begin errors++; $display("FAIL par_err_bad got %b exp 1", PARITYERR); end
  endtask
`endif

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HREADY = 1'b1; HWDATA = '0; GPIOIN = '0;
`ifdef AHB_GPIO_PARITY_EN
    GPIOINPAR = 1'b0;
`endif
    tick(1);
    test_reset;
    test_decode;
    test_output;
    test_back_to_back;
    test_rise;
    test_fall_mask;
    test_no_false_events;
    test_set_beats_clear;
    test_mid_reset;
`ifdef AHB_GPIO_PARITY_EN
    test_parity;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
